// File: rtl/upc_pkg.sv
// rtl/upc_pkg.sv - shared frame constants and FSM state type for the UPC tag link
package upc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // start + 4 data + parity + stop
    localparam int FRAME_BITS = 7;
    localparam int TAG_BITS   = 4;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/upc_bit_timer.sv
// rtl/upc_bit_timer.sv - bit-period timer, pulses bit_end on the last cycle of each line bit
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   clear   : hold the counter at zero (used while the transmitter is idle)
//   bit_end : high on the final cycle of the current bit period
module upc_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    // Wrapping to zero at bit_end makes every state entry start from count 0,
    // since state changes only ever happen on a bit_end cycle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/upc_tag_tx.sv
// rtl/upc_tag_tx.sv - serial transmitter framing a 4-bit UPC tag onto an idle-high line
//   clk        : system clock
//   reset_n    : asynchronous active-low reset, aborts any frame in progress
//   tag_valid  : producer offers tag_data
//   tag_data   : tag bits {u, p, c, m}, u is the MSB and is sent first
//   tag_ready  : transmitter idle and able to accept a tag
//   tx_line    : registered serial line output
//   busy       : frame in progress
//   frame_done : one-cycle pulse on the last cycle of the stop bit
module upc_tag_tx
    import upc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tag_valid,
    input  logic [TAG_BITS-1:0] tag_data,
    output logic                tag_ready,
    output logic                tx_line,
    output logic                busy,
    output logic                frame_done
);

    tx_state_t           state_q, state_d;
    logic [TAG_BITS-1:0] shift_q, shift_d;
    logic                parity_q, parity_d;
    logic [1:0]          idx_q, idx_d;
    logic                tx_line_q, tx_line_d;
    logic                bit_end;

    upc_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == IDLE),
        .bit_end (bit_end)
    );

    // tx_line_d is the level of the bit the FSM is entering, so the line
    // register changes on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        idx_d     = idx_q;
        tx_line_d = tx_line_q;

        case (state_q)
            IDLE: begin
                tx_line_d = STOP_LEVEL;
                if (tag_valid) begin
                    state_d   = START;
                    shift_d   = tag_data;
                    parity_d  = ^tag_data;
                    idx_d     = 2'd0;
                    tx_line_d = START_LEVEL;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_line_d = shift_q[TAG_BITS-1];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 2'd3) begin
                        state_d   = PARITY;
                        tx_line_d = parity_q;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        shift_d   = {shift_q[TAG_BITS-2:0], 1'b0};
                        tx_line_d = shift_q[TAG_BITS-2];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    tx_line_d = STOP_LEVEL;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d   = IDLE;
                    idx_d     = 2'd0;
                    tx_line_d = STOP_LEVEL;
                end
            end
            default: begin
                state_d   = IDLE;
                idx_d     = 2'd0;
                tx_line_d = STOP_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            idx_q     <= 2'd0;
            tx_line_q <= STOP_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            idx_q     <= idx_d;
            tx_line_q <= tx_line_d;
        end
    end

    assign tag_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx_line    = tx_line_q;
    assign frame_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_upc_tag_tx.sv
// tb/tb_upc_tag_tx.sv - directed self-checking bench for upc_tag_tx (CLKS_PER_BIT 4 and 1)
module tb_upc_tag_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       tag_valid = 1'b0;
    logic [3:0] tag_data = 4'h0;
    logic       tag_ready, tx_line, busy, frame_done;

    logic       tag_valid1 = 1'b0;
    logic [3:0] tag_data1 = 4'h0;
    logic       tag_ready1, tx_line1, busy1, frame_done1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    upc_tag_tx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tag_valid  (tag_valid),
        .tag_data   (tag_data),
        .tag_ready  (tag_ready),
        .tx_line    (tx_line),
        .busy       (busy),
        .frame_done (frame_done)
    );

    upc_tag_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tag_valid  (tag_valid1),
        .tag_data   (tag_data1),
        .tag_ready  (tag_ready1),
        .tx_line    (tx_line1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a tag and wait (bounded) for the accept edge; returns #1 after it.
    task automatic offer(input logic [3:0] tag, input bit hold_valid);
        int n;
        @(negedge clk);
        tag_valid = 1'b1;
        tag_data  = tag;
        n = 0;
        while (!tag_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, tag_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold_valid) tag_valid = 1'b0;
    endtask

    // seq[6] is the first line bit (start), seq[0] the stop bit.
    task automatic frame_check(input string name, input logic [6:0] seq);
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check($sformatf("%s tx b%0d c%0d", name, k, j), {31'd0, tx_line}, {31'd0, seq[6-k]});
                check($sformatf("%s done b%0d c%0d", name, k, j), {31'd0, frame_done},
                      {31'd0, (k == 6 && j == 3)});
                check($sformatf("%s busy b%0d c%0d", name, k, j), {30'd0, busy, tag_ready}, 32'd2);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle4", {28'd0, tx_line, tag_ready, busy, frame_done}, 32'b1100);
            check("idle1", {28'd0, tx_line1, tag_ready1, busy1, frame_done1}, 32'b1100);
        end

        // 1010: 0,1,0,1,0, parity 0, stop 1
        offer(4'b1010, 1'b0);
        frame_check("t1010", 7'b0101001);
        @(negedge clk);
        check("t1010 ready_back", {30'd0, tag_ready, frame_done}, 32'b10);

        // 0111: parity 1; tag_data scrambled mid-frame must not matter
        offer(4'b0111, 1'b0);
        fork
            frame_check("t0111", 7'b0011111);
            begin
                repeat (10) @(posedge clk);
                #2 tag_data = 4'b0000;
            end
        join
        @(negedge clk);
        check("t0111 ready_back", {31'd0, tag_ready}, 32'd1);

        // Back-to-back with tag_valid held: 1111 (parity 0) then 0001 (parity 1)
        offer(4'b1111, 1'b1);
        tag_data = 4'b0001;
        frame_check("t1111", 7'b0111101);
        @(negedge clk);
        check("b2b idle_gap", {30'd0, tx_line, tag_ready}, 32'b11);
        @(posedge clk);
        #1 tag_valid = 1'b0;
        frame_check("t0001", 7'b0000111);
        @(negedge clk);
        check("t0001 ready_back", {31'd0, tag_ready}, 32'd1);

        // Reset during the DATA bits of 1100
        offer(4'b1100, 1'b0);
        repeat (9) @(posedge clk);
        #1 check("pre_reset busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {29'd0, tx_line, busy, tag_ready}, 32'b101);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset idle", {28'd0, tx_line, tag_ready, busy, frame_done}, 32'b1100);
        offer(4'b0011, 1'b0);
        frame_check("t0011", 7'b0001101);
        @(negedge clk);
        check("t0011 ready_back", {31'd0, tag_ready}, 32'd1);

        // CLKS_PER_BIT = 1: 1000 -> 0,1,0,0,0,1,1
        begin
            logic [6:0] seq1;
            int n;
            seq1 = 7'b0100011;
            @(negedge clk);
            tag_valid1 = 1'b1;
            tag_data1  = 4'b1000;
            n = 0;
            while (!tag_ready1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("cpb1 accept_wait", {31'd0, tag_ready1}, 32'd1);
            @(posedge clk);
            #1 tag_valid1 = 1'b0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                check($sformatf("cpb1 tx b%0d", k), {31'd0, tx_line1}, {31'd0, seq1[6-k]});
                check($sformatf("cpb1 done b%0d", k), {31'd0, frame_done1}, {31'd0, (k == 6)});
                check($sformatf("cpb1 busy b%0d", k), {31'd0, busy1}, 32'd1);
            end
            @(negedge clk);
            check("cpb1 ready_back", {30'd0, tag_ready1, tx_line1}, 32'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
